// File: rtl/icache_cwf.sv
// icache_cwf: set-associative instruction cache with critical-word-first, wrapping line refill.
// Latency: hits return combinationally in the request cycle; a miss starts its refill the next cycle.
// Backpressure: cpu_stall while the requested word is unavailable; memory beats accepted on mem_valid strobes.
// Option: define ICACHE_PLRU_EN for tree pseudo-LRU replacement; otherwise per-set round-robin.
module icache_cwf #(
   parameter int ADDR_WIDTH       = 32,
   parameter int DATA_WIDTH       = 32,
   parameter int NUM_WAYS         = 4,
   parameter int NUM_SETS         = 64,
   parameter int CACHE_LINE_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  cpu_req,
   output logic [DATA_WIDTH-1:0] cpu_data,
   output logic                  cpu_valid,
   output logic                  cpu_stall,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_req,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  mem_valid,
   input  logic                  invalidate
);

   localparam int OFF_W = $clog2(CACHE_LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(NUM_WAYS);
   localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t state_q, state_d;

   // Request address fields; byte-offset bits are not part of the lookup.
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [OFF_W-1:0] req_off;
   logic             unused_addr_bits;

   assign req_off          = cpu_addr[OFF_W+1:2];
   assign req_idx          = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
   assign req_tag          = cpu_addr[ADDR_WIDTH-1:OFF_W+IDX_W+2];
   assign unused_addr_bits = ^cpu_addr[1:0];

   // Line storage
   logic [DATA_WIDTH-1:0] data_q  [NUM_WAYS][NUM_SETS][CACHE_LINE_WORDS];
   logic [TAG_W-1:0]      tag_q   [NUM_WAYS][NUM_SETS];
   logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];

   // Refill context captured at miss time
   logic [TAG_W-1:0]            st_tag;
   logic [IDX_W-1:0]            st_idx;
   logic [OFF_W-1:0]            crit_q;
   logic [WAY_W-1:0]            victim_q;
   logic [OFF_W-1:0]            cnt_q;
   logic [CACHE_LINE_WORDS-1:0] filled_q;

   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic             has_inv;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] policy_way;
   logic [WAY_W-1:0] victim;
   logic [OFF_W-1:0] beat_off;
   logic             last_beat;
   logic             line_match;
   logic             idle_miss;
   logic             beat_acc;
   logic             fill_last;

   assign beat_off   = crit_q + cnt_q;
   assign last_beat  = (cnt_q == OFF_W'(CACHE_LINE_WORDS - 1));
   assign line_match = (req_tag == st_tag) && (req_idx == st_idx);
   assign idle_miss  = !invalidate && (state_q == IDLE) && cpu_req && !hit;
   assign beat_acc   = !invalidate && (state_q == REFILL) && mem_valid;
   assign fill_last  = beat_acc && last_beat;

   // Tag lookup across all ways of the requested set
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Victim: lowest invalid way first, replacement policy otherwise
   always_comb begin
      has_inv = 1'b0;
      inv_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_q[req_idx][w]) begin
            has_inv = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
      victim = has_inv ? inv_way : policy_way;
   end

`ifdef ICACHE_PLRU_EN
   // Tree bits in heap order; a 1 means the victim lies in the right subtree.
   logic [NUM_WAYS-2:0] plru_q [NUM_SETS];
   logic                idle_hit;

   assign idle_hit = !invalidate && (state_q == IDLE) && cpu_req && hit;

   function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] tree,
                                                      input logic [WAY_W-1:0]    way);
      logic [NUM_WAYS-2:0] t;
      int                  node;
      t    = tree;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         t[node] = ~way[WAY_W-1-l];
         node    = 2 * node + 1 + int'(way[WAY_W-1-l]);
      end
      return t;
   endfunction

   function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] tree);
      logic [WAY_W-1:0] way;
      int               node;
      way  = '0;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         way[WAY_W-1-l] = tree[node];
         node           = 2 * node + 1 + int'(tree[node]);
      end
      return way;
   endfunction

   assign policy_way = plru_victim(plru_q[req_idx]);

   // Point the tree away from every hit and every filled way
   always_ff @(posedge clk) begin
      if (rst || invalidate) begin
         for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
      end else if (idle_hit) begin
         plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
      end else if (fill_last) begin
         plru_q[st_idx] <= plru_touch(plru_q[st_idx], victim_q);
      end
   end
`else
   logic [WAY_W-1:0] rr_q [NUM_SETS];

   assign policy_way = rr_q[req_idx];

   // Round-robin pointer advances once per completed fill
   always_ff @(posedge clk) begin
      if (rst || invalidate) begin
         for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
      end else if (fill_last) begin
         rr_q[st_idx] <= rr_q[st_idx] + WAY_W'(1);
      end
   end
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and CPU/memory outputs
   always_comb begin
      state_d   = state_q;
      cpu_valid = 1'b0;
      cpu_stall = 1'b0;
      cpu_data  = '0;
      mem_req   = 1'b0;
      mem_addr  = '0;
      if (rst) begin
         state_d = IDLE;
      end else if (invalidate) begin
         state_d   = IDLE;
         cpu_stall = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (cpu_req) begin
                  if (hit) begin
                     cpu_valid = 1'b1;
                     cpu_data  = data_q[hit_way][req_idx][req_off];
                  end else begin
                     cpu_stall = 1'b1;
                     state_d   = REFILL;
                  end
               end
            end
            REFILL: begin
               mem_req  = 1'b1;
               mem_addr = {st_tag, st_idx, beat_off, 2'b00};
               if (mem_valid && last_beat) state_d = IDLE;
               if (cpu_req) begin
                  if (line_match && mem_valid && (beat_off == req_off)) begin
                     cpu_valid = 1'b1;
                     cpu_data  = mem_data;
                  end else if (line_match && filled_q[req_off]) begin
                     cpu_valid = 1'b1;
                     cpu_data  = data_q[victim_q][st_idx][req_off];
                  end else begin
                     cpu_stall = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Valid bits, filled bits, beat count and latched miss context
   always_ff @(posedge clk) begin
      if (rst || invalidate) begin
         for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
         filled_q <= '0;
         cnt_q    <= '0;
         if (rst) begin
            st_tag   <= '0;
            st_idx   <= '0;
            crit_q   <= '0;
            victim_q <= '0;
         end
      end else if (idle_miss) begin
         st_tag   <= req_tag;
         st_idx   <= req_idx;
         crit_q   <= req_off;
         victim_q <= victim;
         cnt_q    <= '0;
         filled_q <= '0;
      end else if (beat_acc) begin
         filled_q[beat_off] <= 1'b1;
         cnt_q              <= cnt_q + OFF_W'(1);
         if (last_beat) valid_q[st_idx][victim_q] <= 1'b1;
      end
   end

   // Data and tag arrays; tag changes only once the whole line is present
   always_ff @(posedge clk) begin
      if (!rst && beat_acc) begin
         data_q[victim_q][st_idx][beat_off] <= mem_data;
         if (last_beat) tag_q[victim_q][st_idx] <= st_tag;
      end
   end

endmodule

// File: tb/tb_icache_cwf.sv
// tb_icache_cwf: directed bench for icache_cwf with a cycle-driven memory model.
// Memory returns word 0xC0DE0000 ^ address for any beat address.
// Replacement expectations follow ICACHE_PLRU_EN when it is defined.
module tb_icache_cwf;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cpu_addr;
   logic        cpu_req;
   logic [31:0] cpu_data;
   logic        cpu_valid;
   logic        cpu_stall;
   logic [31:0] mem_addr;
   logic        mem_req;
   logic [31:0] mem_data;
   logic        mem_valid;
   logic        invalidate;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mdat(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   assign mem_data = mdat(mem_addr);

   icache_cwf dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_req   (cpu_req),
      .cpu_data  (cpu_data),
      .cpu_valid (cpu_valid),
      .cpu_stall (cpu_stall),
      .mem_addr  (mem_addr),
      .mem_req   (mem_req),
      .mem_data  (mem_data),
      .mem_valid (mem_valid),
      .invalidate(invalidate)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; mem_valid = 1'b0; invalidate = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Present a request that must miss in IDLE and advance into the refill
   task automatic start_miss(input logic [31:0] a, input string nm);
      cpu_req = 1'b1; cpu_addr = a; mem_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({cpu_valid, cpu_stall, mem_req} !== 3'b010)
         $display("FAIL %s_miss: valid/stall/req=%b required 010", nm, {cpu_valid, cpu_stall, mem_req});
      else pass_cnt++;
      tick();
   endtask

   // Deliver all beats of a refill, checking the wrapped beat address order
   task automatic do_refill(input logic [31:0] a, input bit chk_stall, input string nm);
      logic [1:0]  w;
      logic [31:0] exp;
      for (int b = 0; b < 4; b++) begin
         mem_valid = 1'b1;
         w   = a[3:2] + 2'(b);
         exp = {a[31:4], w, 2'b00};
         @(negedge clk);
         total_cnt++;
         if (mem_req !== 1'b1 || mem_addr !== exp)
            $display("FAIL %s_beat%0d: mem_req=%b mem_addr=%h required 1 %h", nm, b, mem_req, mem_addr, exp);
         else pass_cnt++;
         if (chk_stall) begin
            total_cnt++;
            if ({cpu_valid, cpu_stall} !== 2'b01)
               $display("FAIL %s_stall%0d: valid/stall=%b required 01", nm, b, {cpu_valid, cpu_stall});
            else pass_cnt++;
         end
         tick();
      end
      mem_valid = 1'b0;
   endtask

   task automatic probe(input logic [31:0] a, input bit exp_hit, input string nm);
      cpu_req = 1'b1; cpu_addr = a; mem_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (cpu_valid !== exp_hit || cpu_stall !== !exp_hit || mem_req !== 1'b0)
         $display("FAIL %s: valid/stall/req=%b required %b%b0", nm, {cpu_valid, cpu_stall, mem_req}, exp_hit, !exp_hit);
      else pass_cnt++;
      if (exp_hit) begin
         total_cnt++;
         if (cpu_data !== mdat(a)) $display("FAIL %s_data: cpu_data=%h required %h", nm, cpu_data, mdat(a));
         else pass_cnt++;
      end
      tick();
      cpu_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h108; mem_valid = 1'b0; invalidate = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({cpu_valid, cpu_stall, mem_req} !== 3'b000 || mem_addr !== 32'h0 || cpu_data !== 32'h0)
         $display("FAIL reset_during: v/s/r=%b addr=%h data=%h required 000 0 0", {cpu_valid, cpu_stall, mem_req}, mem_addr, cpu_data);
      else pass_cnt++;
      tick();
      rst = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({cpu_valid, cpu_stall, mem_req} !== 3'b000 || mem_addr !== 32'h0 || cpu_data !== 32'h0)
         $display("FAIL reset_after: v/s/r=%b addr=%h data=%h required 000 0 0", {cpu_valid, cpu_stall, mem_req}, mem_addr, cpu_data);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_cold_miss();
      do_reset();
      start_miss(32'h108, "cold");
      // Beat not yet returned: critical word address, still stalled
      mem_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h108 || {cpu_valid, cpu_stall} !== 2'b01)
         $display("FAIL cold_wait: req=%b addr=%h v/s=%b required 1 00000108 01", mem_req, mem_addr, {cpu_valid, cpu_stall});
      else pass_cnt++;
      tick();
      // First beat forwards the critical word
      mem_valid = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({cpu_valid, cpu_stall} !== 2'b10 || cpu_data !== mdat(32'h108))
         $display("FAIL cold_cwf: v/s=%b data=%h required 10 %h", {cpu_valid, cpu_stall}, cpu_data, mdat(32'h108));
      else pass_cnt++;
      tick();
      // 0x10C not yet filled
      mem_valid = 1'b0; cpu_addr = 32'h10C;
      @(negedge clk);
      total_cnt++;
      if (mem_addr !== 32'h10C || {cpu_valid, cpu_stall} !== 2'b01)
         $display("FAIL cold_10c_wait: addr=%h v/s=%b required 0000010c 01", mem_addr, {cpu_valid, cpu_stall});
      else pass_cnt++;
      tick();
      mem_valid = 1'b1; cpu_req = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({cpu_valid, cpu_stall} !== 2'b00)
         $display("FAIL cold_noreq: v/s=%b required 00", {cpu_valid, cpu_stall});
      else pass_cnt++;
      tick();
      // 0x10C now served from storage; memory moved on to the wrapped word
      mem_valid = 1'b0; cpu_req = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({cpu_valid, cpu_stall} !== 2'b10 || cpu_data !== mdat(32'h10C) || mem_addr !== 32'h100)
         $display("FAIL cold_10c_filled: v/s=%b data=%h addr=%h required 10 %h 00000100", {cpu_valid, cpu_stall}, cpu_data, mem_addr, mdat(32'h10C));
      else pass_cnt++;
      tick();
      mem_valid = 1'b1; cpu_req = 1'b0;
      tick();
      @(negedge clk);
      total_cnt++;
      if (mem_addr !== 32'h104 || mem_req !== 1'b1)
         $display("FAIL cold_last_beat: addr=%h req=%b required 00000104 1", mem_addr, mem_req);
      else pass_cnt++;
      tick();
      mem_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({cpu_valid, cpu_stall, mem_req} !== 3'b000 || cpu_data !== 32'h0)
         $display("FAIL cold_done_idle: v/s/r=%b data=%h required 000 0", {cpu_valid, cpu_stall, mem_req}, cpu_data);
      else pass_cnt++;
      tick();
      probe(32'h100, 1'b1, "hit_100");
      probe(32'h104, 1'b1, "hit_104");
      probe(32'h10C, 1'b1, "hit_10c");
   endtask

   task automatic test_replacement();
      logic [31:0] lines [4];
      lines = '{32'h0000, 32'h0400, 32'h0800, 32'h0C00};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         start_miss(lines[i], "repl_fill");
         cpu_req = 1'b0;
         do_refill(lines[i], 1'b0, "repl_fill");
      end
      probe(32'h0000, 1'b1, "repl_touch0a");
      probe(32'h0004, 1'b1, "repl_touch0b");
      start_miss(32'h1000, "repl_fifth");
      cpu_req = 1'b0;
      do_refill(32'h1000, 1'b0, "repl_fifth");
      probe(32'h1000, 1'b1, "repl_new_line");
      probe(32'h0400, 1'b1, "repl_keep_400");
`ifdef ICACHE_PLRU_EN
      probe(32'h0000, 1'b1, "repl_keep_way0");
      probe(32'h0C00, 1'b1, "repl_keep_c00");
      probe(32'h0800, 1'b0, "repl_evict_800");
`else
      probe(32'h0800, 1'b1, "repl_keep_800");
      probe(32'h0C00, 1'b1, "repl_keep_c00");
      probe(32'h0000, 1'b0, "repl_evict_way0");
`endif
   endtask

   task automatic test_invalidate();
      do_reset();
      start_miss(32'h108, "inv");
      cpu_req = 1'b0; mem_valid = 1'b1;
      tick();
      tick();
      mem_valid = 1'b0; invalidate = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h108;
      @(negedge clk);
      total_cnt++;
      if ({cpu_valid, cpu_stall, mem_req} !== 3'b010)
         $display("FAIL inv_during: v/s/r=%b required 010", {cpu_valid, cpu_stall, mem_req});
      else pass_cnt++;
      tick();
      invalidate = 1'b0; cpu_req = 1'b0; mem_valid = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({cpu_valid, cpu_stall, mem_req} !== 3'b000 || mem_addr !== 32'h0)
         $display("FAIL inv_next: v/s/r=%b addr=%h required 000 0", {cpu_valid, cpu_stall, mem_req}, mem_addr);
      else pass_cnt++;
      tick();
      mem_valid = 1'b0;
      start_miss(32'h108, "inv_rerequest");
      cpu_req = 1'b0;
      do_refill(32'h108, 1'b0, "inv_refill");
      probe(32'h108, 1'b1, "inv_hit_after");
   endtask

   task automatic test_redirect();
      do_reset();
      start_miss(32'h108, "redir_old");
      cpu_addr = 32'h2000;
      do_refill(32'h108, 1'b1, "redir_old");
      start_miss(32'h2000, "redir_new");
      mem_valid = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (mem_addr !== 32'h2000 || {cpu_valid, cpu_stall} !== 2'b10 || cpu_data !== mdat(32'h2000))
         $display("FAIL redir_new_cwf: addr=%h v/s=%b data=%h required 00002000 10 %h", mem_addr, {cpu_valid, cpu_stall}, cpu_data, mdat(32'h2000));
      else pass_cnt++;
      tick();
      cpu_req = 1'b0;
      for (int b = 1; b < 4; b++) tick();
      mem_valid = 1'b0;
      probe(32'h200C, 1'b1, "redir_hit_new");
      probe(32'h0108, 1'b1, "redir_hit_old");
   endtask

   task automatic test_rst_mid_refill();
      do_reset();
      start_miss(32'h2000, "rst_prefill");
      cpu_req = 1'b0;
      do_refill(32'h2000, 1'b0, "rst_prefill");
      probe(32'h2000, 1'b1, "rst_prefill_hit");
      start_miss(32'h108, "rst_mid");
      mem_valid = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({cpu_valid, cpu_stall, mem_req} !== 3'b000 || mem_addr !== 32'h0 || cpu_data !== 32'h0)
         $display("FAIL rst_mid_during: v/s/r=%b addr=%h data=%h required 000 0 0", {cpu_valid, cpu_stall, mem_req}, mem_addr, cpu_data);
      else pass_cnt++;
      tick();
      rst = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({cpu_valid, cpu_stall, mem_req} !== 3'b000 || mem_addr !== 32'h0 || cpu_data !== 32'h0)
         $display("FAIL rst_mid_after: v/s/r=%b addr=%h data=%h required 000 0 0", {cpu_valid, cpu_stall, mem_req}, mem_addr, cpu_data);
      else pass_cnt++;
      tick();
      mem_valid = 1'b0;
      start_miss(32'h2000, "rst_old_line");
      cpu_req = 1'b0;
      do_refill(32'h2000, 1'b0, "rst_old_refill");
      start_miss(32'h10C, "rst_partial_line");
      cpu_req = 1'b0;
      do_refill(32'h10C, 1'b0, "rst_partial_refill");
      probe(32'h108, 1'b1, "rst_hit_after");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_cold_miss();
      test_replacement();
      test_invalidate();
      test_redirect();
      test_rst_mid_refill();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/icache_cwf.md
ICACHE_CWF -- requirements
Module: icache_cwf

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter NUM_WAYS, default 4, associativity; power of two, at least 2.
REQ-004 SHALL have parameter NUM_SETS, default 64, sets; power of two.
REQ-005 SHALL have parameter CACHE_LINE_WORDS, default 4, words per line; power of two, at least 2.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port cpu_addr, input, ADDR_WIDTH, fetch byte address; bits [1:0] ignored.
REQ-010 SHALL have port cpu_req, input, 1, fetch request.
REQ-011 SHALL have port cpu_data, output, DATA_WIDTH, fetched word.
REQ-012 SHALL have port cpu_valid, output, 1, cpu_data valid this cycle.
REQ-013 SHALL have port cpu_stall, output, 1, request not served this cycle.
REQ-014 SHALL have port mem_addr, output, ADDR_WIDTH, word-aligned beat address.
REQ-015 SHALL have port mem_req, output, 1, beat request; mem_addr held stable while high.
REQ-016 SHALL have port mem_data, input, DATA_WIDTH, returned beat.
REQ-017 SHALL have port mem_valid, input, 1, one-cycle beat strobe; ignored while mem_req low.
REQ-018 SHALL have port invalidate, input, 1, FENCE.I flush.

Function
REQ-019 SHALL split cpu_addr into tag, index and word-offset fields above bits [1:0].
REQ-020 SHALL implement two states: IDLE and REFILL.
REQ-021 In IDLE with cpu_req and a hit, SHALL drive cpu_valid=1, cpu_stall=0 and the hit word combinationally in the same cycle.
REQ-022 In IDLE with cpu_req and a miss, SHALL drive cpu_stall=1 and mem_req=0, latch address, tag, index, critical word and victim way, and enter REFILL next cycle.
REQ-023 SHALL select as victim the lowest-index invalid way if one exists, otherwise the way given by the replacement policy.
REQ-024 In REFILL, SHALL hold mem_req=1 with mem_addr = {line base, (critical word + beat count) mod CACHE_LINE_WORDS, 2'b00}, so the critical word is fetched first and the line wraps.
REQ-025 On each accepted beat, SHALL write the word into the victim line, set that word's filled bit and increment the beat count.
REQ-026 In REFILL, if cpu_addr matches the refilling line, SHALL serve the word (cpu_valid=1, cpu_stall=0) from mem_data when mem_valid carries that word, or from storage when its filled bit is set; otherwise it SHALL stall.
REQ-027 On the last beat, SHALL set the line's valid bit and tag, update the replacement state and return to IDLE next cycle; mem_req drops that next cycle.
REQ-028 A cpu_addr outside the refilling line during REFILL SHALL stall without aborting the refill; it is evaluated in IDLE after the refill completes.
REQ-029 SHALL update replacement state on every IDLE hit and on every fill.
REQ-030 invalidate SHALL clear all valid bits, filled bits and replacement state, abort any refill and force IDLE next cycle, with priority over all other events except rst.
REQ-031 While invalidate is high, SHALL drive cpu_valid=0, cpu_stall=1 and mem_req=0; beats arriving after an abort SHALL be discarded.
REQ-032 With cpu_req low in IDLE, SHALL drive cpu_valid=0, cpu_stall=0 and mem_req=0.

Reset
REQ-033 rst SHALL clear all valid bits, filled bits, replacement state, beat count and latched fields, and force IDLE.
REQ-034 During and after reset, SHALL drive cpu_valid=0, cpu_stall=0, mem_req=0, mem_addr=0 and cpu_data=0 until a request occurs; rst mid-refill aborts the refill.

Configuration
REQ-035 With ICACHE_PLRU_EN defined, SHALL use tree pseudo-LRU with NUM_WAYS-1 bits per set; each access points the tree bits away from the accessed way.
REQ-036 Without ICACHE_PLRU_EN, SHALL use a per-set round-robin counter that advances on fills only and wraps from NUM_WAYS-1 to 0; the tree storage is absent.

Verification
REQ-037 Bench SHALL check: cold miss at 0x0000_0108 (4 words) -> mem_addr beats 0x108, 0x10C, 0x100, 0x104; cpu_valid in the first mem_valid cycle with that data; 0x10C then served as soon as its filled bit is set.
REQ-038 Bench SHALL check: after the fill, a request at 0x0000_0100 -> cpu_valid=1 in the same cycle, mem_req=0.
REQ-039 Bench SHALL check: five lines mapping to set 0 with PLRU and hits re-touching way 0 -> the fifth fill evicts a way other than 0; without the macro, way 0 is evicted.
REQ-040 Bench SHALL check: invalidate after the second beat -> mem_req=0 next cycle, late mem_valid ignored, and a later request to 0x108 misses again.
REQ-041 Bench SHALL check: cpu_addr redirected to 0x0000_2000 mid-refill -> stall until the old line completes, then a new miss and refill of 0x2000.
REQ-042 Bench SHALL check: rst asserted mid-refill -> IDLE next cycle with all outputs 0, and all lines miss afterwards.
